// File: rtl/nfc_cmd_addr_latch.sv
// nfc_cmd_addr_latch: NAND command/address latch cycle generator.
// Takes one descriptor (opcode, address bytes, optional second opcode, way)
// and emits the 4-phase-per-clock CE/CLE/ALE/WE/RE/DQ words for the PHY.
// Optional build macro NFC_CMD_RB_WAIT_EN adds a tWB delay plus an R/B wait
// before the completion pulse.
module nfc_cmd_addr_latch #(
    parameter int NumberOfWays  = 4,
    parameter int MaxAddrBytes  = 5,
    parameter int CESetupCycles = 2,
    parameter int HoldCycles    = 2,
    parameter int TwbCycles     = 10
) (
    input  logic                              iSystemClock,
    input  logic                              iModuleReset,
    input  logic                              iCmd_Valid,
    output logic                              oCmd_Ready,
    input  logic [7:0]                        iCmd_Opcode,
    input  logic [8*MaxAddrBytes-1:0]         iCmd_Addr,
    input  logic [2:0]                        iCmd_AddrCount,
    input  logic                              iCmd_HasSecond,
    input  logic [7:0]                        iCmd_Opcode2,
    input  logic [$clog2(NumberOfWays)-1:0]   iCmd_TargetID,
    output logic                              oDone,
    output logic [2*NumberOfWays-1:0]         oACG_PHY_ChipEnable,
    output logic [3:0]                        oACG_PHY_WriteEnable,
    output logic [3:0]                        oACG_PHY_ReadEnable,
    output logic [3:0]                        oACG_PHY_CommandLatchEnable,
    output logic [3:0]                        oACG_PHY_AddressLatchEnable,
    output logic [31:0]                       oACG_PHY_DQ,
    output logic                              oACG_PHY_DQOutEnable,
    output logic                              oACG_PHY_DQSOutEnable,
    output logic [7:0]                        oACG_PHY_DQStrobe,
    input  logic [NumberOfWays-1:0]           iPHY_ACG_ReadyBusy
);
    localparam int TW = $clog2(NumberOfWays);

    typedef enum logic [3:0] {
        IDLE, CE_SETUP, CMD1_LO, CMD1_HI, ADDR_LO, ADDR_HI,
        CMD2_LO, CMD2_HI, HOLD, DONE
`ifdef NFC_CMD_RB_WAIT_EN
        , WAIT_TWB, WAIT_RB
`endif
    } state_t;

    state_t state, stateNext;
    logic [7:0] cycCnt;
    logic [2:0] addrIdx, addrIdxNext;
    logic       accept;

    // Latched descriptor; inputs are ignored after accept
    logic [7:0]                   opcode, opcode2;
    logic [MaxAddrBytes-1:0][7:0] addrReg;
    logic [2:0]                   addrCnt;
    logic                         hasSecond;
    logic [TW-1:0]                tgt, tgtNext;

    // Values the output registers take at the next edge
    logic [2*NumberOfWays-1:0] ceNext;
    logic [3:0]                weNext, cleNext, aleNext;
    logic [7:0]                dqByteNext;
    logic                      oeNext, doneNext, readyNext;

`ifdef NFC_CMD_RB_WAIT_EN
    logic rbReady;
    assign rbReady = iPHY_ACG_ReadyBusy[tgt];
`else
    logic unusedSink;
    assign unusedSink = ^{iPHY_ACG_ReadyBusy, 32'(TwbCycles)};
`endif

    // Constant pins: RE never toggles, no DQS drive for command/address cycles
    assign oACG_PHY_ReadEnable   = 4'hF;
    assign oACG_PHY_DQSOutEnable = 1'b0;
    assign oACG_PHY_DQStrobe     = 8'h00;

    // State register, phase counter and byte index
    always_ff @(posedge iSystemClock or posedge iModuleReset) begin
        if (iModuleReset) begin
            state   <= IDLE;
            cycCnt  <= '0;
            addrIdx <= '0;
        end else begin
            state   <= stateNext;
            cycCnt  <= (stateNext != state) ? 8'd0 : cycCnt + 8'd1;
            addrIdx <= addrIdxNext;
        end
    end

    // Descriptor capture at accept; address count clamped to the slot limit
    always_ff @(posedge iSystemClock or posedge iModuleReset) begin
        if (iModuleReset) begin
            opcode    <= '0;
            opcode2   <= '0;
            addrReg   <= '0;
            addrCnt   <= '0;
            hasSecond <= 1'b0;
            tgt       <= '0;
        end else if (accept) begin
            opcode    <= iCmd_Opcode;
            opcode2   <= iCmd_Opcode2;
            addrReg   <= iCmd_Addr;
            addrCnt   <= (iCmd_AddrCount > 3'(MaxAddrBytes)) ? 3'(MaxAddrBytes)
                                                             : iCmd_AddrCount;
            hasSecond <= iCmd_HasSecond;
            tgt       <= iCmd_TargetID;
        end
    end

    // Next-state sequencing and decode of the next cycle's pin values
    always_comb begin
        stateNext   = state;
        addrIdxNext = addrIdx;
        accept      = 1'b0;
        case (state)
            IDLE: if (iCmd_Valid) begin
                accept    = 1'b1;
                stateNext = CE_SETUP;
            end
            CE_SETUP: if (cycCnt == 8'(CESetupCycles - 1)) stateNext = CMD1_LO;
            CMD1_LO:  stateNext = CMD1_HI;
            CMD1_HI: begin
                if (addrCnt != 3'd0)  stateNext = ADDR_LO;
                else if (hasSecond)   stateNext = CMD2_LO;
                else                  stateNext = HOLD;
            end
            ADDR_LO:  stateNext = ADDR_HI;
            ADDR_HI: begin
                if (addrIdx == addrCnt - 3'd1)
                    stateNext = hasSecond ? CMD2_LO : HOLD;
                else begin
                    stateNext   = ADDR_LO;
                    addrIdxNext = addrIdx + 3'd1;
                end
            end
            CMD2_LO:  stateNext = CMD2_HI;
            CMD2_HI:  stateNext = HOLD;
`ifdef NFC_CMD_RB_WAIT_EN
            HOLD:     if (cycCnt == 8'(HoldCycles - 1)) stateNext = WAIT_TWB;
            WAIT_TWB: if (cycCnt == 8'(TwbCycles - 1))  stateNext = WAIT_RB;
            WAIT_RB:  if (rbReady) stateNext = DONE;
`else
            HOLD:     if (cycCnt == 8'(HoldCycles - 1)) stateNext = DONE;
`endif
            DONE:     stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
        if (accept) addrIdxNext = '0;

        tgtNext    = accept ? iCmd_TargetID : tgt;
        ceNext     = '0;
        weNext     = 4'hF;
        cleNext    = 4'h0;
        aleNext    = 4'h0;
        dqByteNext = 8'h00;
        oeNext     = 1'b0;
        doneNext   = (stateNext == DONE);
        readyNext  = (stateNext == IDLE);

        if (stateNext != IDLE && stateNext != DONE)
            ceNext[2*tgtNext +: 2] = 2'b11;

        case (stateNext)
            CMD1_LO, CMD1_HI: begin
                dqByteNext = opcode;
                cleNext    = 4'hF;
                oeNext     = 1'b1;
            end
            ADDR_LO, ADDR_HI: begin
                dqByteNext = addrReg[addrIdxNext];
                aleNext    = 4'hF;
                oeNext     = 1'b1;
            end
            CMD2_LO, CMD2_HI: begin
                dqByteNext = opcode2;
                cleNext    = 4'hF;
                oeNext     = 1'b1;
            end
            default: ;
        endcase
        if (stateNext == CMD1_LO || stateNext == ADDR_LO || stateNext == CMD2_LO)
            weNext = 4'h0;
    end

    // Output registers; reset drives the idle pin levels immediately
    always_ff @(posedge iSystemClock or posedge iModuleReset) begin
        if (iModuleReset) begin
            oCmd_Ready                  <= 1'b1;
            oDone                       <= 1'b0;
            oACG_PHY_ChipEnable         <= '0;
            oACG_PHY_WriteEnable        <= 4'hF;
            oACG_PHY_CommandLatchEnable <= 4'h0;
            oACG_PHY_AddressLatchEnable <= 4'h0;
            oACG_PHY_DQ                 <= 32'h0;
            oACG_PHY_DQOutEnable        <= 1'b0;
        end else begin
            oCmd_Ready                  <= readyNext;
            oDone                       <= doneNext;
            oACG_PHY_ChipEnable         <= ceNext;
            oACG_PHY_WriteEnable        <= weNext;
            oACG_PHY_CommandLatchEnable <= cleNext;
            oACG_PHY_AddressLatchEnable <= aleNext;
            oACG_PHY_DQ                 <= {4{dqByteNext}};
            oACG_PHY_DQOutEnable        <= oeNext;
        end
    end

endmodule

// File: tb/tb_nfc_cmd_addr_latch.sv
// Bench for nfc_cmd_addr_latch: table of descriptors with expected latency
// and CE pattern; expected byte slots are queued at drive time and popped on
// each WE-low cycle. Hand sequences cover mid-command reset and the R/B wait.
module tb_nfc_cmd_addr_latch;
    localparam int NW = 4, MAB = 5, CES = 2, HOLDC = 2, TWB = 10;
`ifdef NFC_CMD_RB_WAIT_EN
    localparam int RBX = TWB + 1;
`else
    localparam int RBX = 0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        cmdValid = 1'b0, cmdReady, hasSecond = 1'b0, done;
    logic [7:0]  opcode = '0, opcode2 = '0;
    logic [39:0] addr = '0;
    logic [2:0]  addrCount = '0;
    logic [1:0]  targetId = '0;
    logic [7:0]  ce, dqStrobe;
    logic [3:0]  we, re, cle, ale, rb = 4'hF;
    logic [31:0] dq;
    logic        dqOe, dqsOe;

    nfc_cmd_addr_latch #(.NumberOfWays(NW), .MaxAddrBytes(MAB), .CESetupCycles(CES),
                         .HoldCycles(HOLDC), .TwbCycles(TWB)) dut (
        .iSystemClock(clk), .iModuleReset(rst),
        .iCmd_Valid(cmdValid), .oCmd_Ready(cmdReady),
        .iCmd_Opcode(opcode), .iCmd_Addr(addr), .iCmd_AddrCount(addrCount),
        .iCmd_HasSecond(hasSecond), .iCmd_Opcode2(opcode2), .iCmd_TargetID(targetId),
        .oDone(done), .oACG_PHY_ChipEnable(ce),
        .oACG_PHY_WriteEnable(we), .oACG_PHY_ReadEnable(re),
        .oACG_PHY_CommandLatchEnable(cle), .oACG_PHY_AddressLatchEnable(ale),
        .oACG_PHY_DQ(dq), .oACG_PHY_DQOutEnable(dqOe),
        .oACG_PHY_DQSOutEnable(dqsOe), .oACG_PHY_DQStrobe(dqStrobe),
        .iPHY_ACG_ReadyBusy(rb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [39:0] addr;
        logic [2:0]  cnt;
        logic        has2;
        logic [7:0]  op2;
        logic [1:0]  tgt;
        int          lat;     // cycles from accept to oDone, default build
        logic [7:0]  ceMask;  // expected CE word while the command is active
    } vec_t;

    typedef struct {
        logic [7:0] dq;
        logic       cle;
        logic       ale;
    } slot_t;

    slot_t sbq[$];
    vec_t  vecs[5];
    int    nChecks = 0, nErrors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        chk({tag, "_ready"}, 32'(cmdReady), 32'd1);
        chk({tag, "_done"},  32'(done),     32'd0);
        chk({tag, "_ce"},    32'(ce),       32'h00);
        chk({tag, "_we"},    32'(we),       32'hF);
        chk({tag, "_re"},    32'(re),       32'hF);
        chk({tag, "_clale"}, 32'({cle, ale}), 32'h00);
        chk({tag, "_dq"},    dq,            32'h0);
        chk({tag, "_oe"},    32'({dqOe, dqsOe, dqStrobe}), 32'h0);
    endtask

    // Drive one descriptor and check every cycle until Ready returns.
    // abortAt > 0 asserts reset after the checks of that cycle.
    task automatic runCmd(input vec_t v, input int abortAt);
        int    w = 0, n, nSlots, total, j;
        slot_t cur, s;
        while (!cmdReady && w < 50) begin step(); w++; end
        chk("ready_wait", 32'(cmdReady), 32'd1);

        n = (v.cnt > 3'd5) ? 5 : int'(v.cnt);
        s.dq = v.op; s.cle = 1'b1; s.ale = 1'b0; sbq.push_back(s);
        for (int k = 0; k < n; k++) begin
            s.dq = v.addr[8*k +: 8]; s.cle = 1'b0; s.ale = 1'b1; sbq.push_back(s);
        end
        if (v.has2) begin
            s.dq = v.op2; s.cle = 1'b1; s.ale = 1'b0; sbq.push_back(s);
        end
        nSlots = sbq.size();
        total  = v.lat + RBX;

        opcode = v.op; addr = v.addr; addrCount = v.cnt; hasSecond = v.has2;
        opcode2 = v.op2; targetId = v.tgt; cmdValid = 1'b1;
        step();
        // Post-accept input changes must have no effect
        cmdValid = 1'b0; opcode = ~v.op; addr = {$urandom, 8'hA5}; opcode2 = ~v.op2;
        targetId = v.tgt + 2'd1; addrCount = 3'd1; hasSecond = ~v.has2;
        cur.dq = '0; cur.cle = 1'b0; cur.ale = 1'b0;

        for (int i = 1; i <= total + 1; i++) begin
            if (i <= total) begin
                chk("done",  32'(done), 32'(i == total));
                chk("ready", 32'(cmdReady), 32'd0);
                chk("re",    32'(re), 32'hF);
                chk("ce",    32'(ce), (i < total) ? 32'(v.ceMask) : 32'h0);
                if (i <= CES) begin
                    chk("setup_we", 32'(we), 32'hF);
                    chk("setup_latch_oe", 32'({cle, ale, dqOe}), 32'h0);
                end else if (i <= CES + 2*nSlots) begin
                    j = i - CES;
                    if (j % 2 == 1) begin
                        if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                        else cur = sbq.pop_front();
                        chk("slot_we_lo", 32'(we), 32'h0);
                    end else begin
                        chk("slot_we_hi", 32'(we), 32'hF);
                    end
                    chk("slot_dq",  dq, {4{cur.dq}});
                    chk("slot_cle", 32'(cle), cur.cle ? 32'hF : 32'h0);
                    chk("slot_ale", 32'(ale), cur.ale ? 32'hF : 32'h0);
                    chk("slot_oe",  32'(dqOe), 32'd1);
                end else if (i < total) begin
                    chk("hold_we", 32'(we), 32'hF);
                    chk("hold_latch_oe", 32'({cle, ale, dqOe}), 32'h0);
                    chk("hold_dq", dq, 32'h0);
                end
            end else begin
                chk("ready_back", 32'(cmdReady), 32'd1);
                chk("done_once",  32'(done), 32'd0);
            end
            if (i == abortAt) begin
                rst = 1'b1;
                #1;
                checkIdle("abort");
                sbq.delete();
                step();
                chk("abort_done", 32'(done), 32'd0);
                rst = 1'b0;
                step();
                checkIdle("abort_rel");
                return;
            end
            if (i <= total) step();
        end
        chk("sb_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h00, 40'h05_04_03_02_01, 3'd5, 1'b1, 8'h30, 2'd2, 19, 8'h30};
        vecs[1] = '{8'hFF, 40'h0,              3'd0, 1'b0, 8'h00, 2'd0,  7, 8'h03};
        vecs[2] = '{8'h80, 40'hEE_DD_CC_BB_AA, 3'd7, 1'b0, 8'h00, 2'd3, 17, 8'hC0};
        vecs[3] = '{8'h60, 40'h00_00_33_22_11, 3'd3, 1'b1, 8'hD0, 2'd1, 15, 8'h0C};
        vecs[4] = '{8'h05, 40'h00_00_00_9A_78, 3'd2, 1'b1, 8'hE0, 2'd0, 13, 8'h03};

        rst = 1'b1;
        repeat (3) step();
        checkIdle("in_reset");
        rst = 1'b0;
        step();
        checkIdle("reset_rel");

        for (int t = 0; t < 5; t++) runCmd(vecs[t], 0);

        // Reset during ADDR_HI of byte 2 (cycle 10), then a clean command
        runCmd(vecs[0], 10);
        runCmd(vecs[1], 0);
        runCmd(vecs[0], 0);

`ifdef NFC_CMD_RB_WAIT_EN
        // R/B held low 30 cycles past tWB on way 1
        rb[1] = 1'b0;
        opcode = 8'h70; addrCount = 3'd0; hasSecond = 1'b0; targetId = 2'd1;
        cmdValid = 1'b1;
        step();
        cmdValid = 1'b0;
        for (int i = 1; i <= CES + 2 + HOLDC + TWB + 30; i++) begin
            chk("rb_wait_ce",   32'(ce), 32'h0C);
            chk("rb_wait_done", 32'(done), 32'd0);
            step();
        end
        rb[1] = 1'b1;
        step();
        chk("rb_done", 32'(done), 32'd1);
        chk("rb_done_ce", 32'(ce), 32'h00);
        step();
        chk("rb_ready", 32'(cmdReady), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule

// File: doc/nfc_cmd_addr_latch.md
# nfc_cmd_addr_latch

Upstream atomic generator for NAND command/address latch cycles. It accepts one command descriptor per handshake: opcode, 0..MaxAddrBytes address bytes, optional second opcode and target way. It emits the 4-phase-per-clock CE/CLE/ALE/WE/RE/DQ nibble words consumed by the NAND physical top. It runs in the system clock domain; all outputs are registered.

## Interface
- NumberOfWays, 4, CE/RB ways; power of two
- MaxAddrBytes, 5, maximum address bytes per command
- CESetupCycles, 2, cycles CE is asserted before the first WE-low
- HoldCycles, 2, cycles CE is held after the last WE-high
- TwbCycles, 10, cycles before sampling R/B (macro only)

- iSystemClock  in  1  system clock (SDR 100 MHz)
- iModuleReset  in  1  asynchronous, active-high reset
- iCmd_Valid / oCmd_Ready  in/out  1/1  descriptor handshake
- iCmd_Opcode  in  8  first command byte
- iCmd_Addr  in  8*MaxAddrBytes  address bytes; byte 0 is in [7:0] and is sent first
- iCmd_AddrCount  in  3  number of address bytes
- iCmd_HasSecond / iCmd_Opcode2  in  1/8  optional trailing command byte
- iCmd_TargetID  in  $clog2(NumberOfWays)  way select
- oDone  out  1  one-cycle completion pulse
- oACG_PHY_ChipEnable  out  2*NumberOfWays  per way 2 bits (both equal), 1 = CE active
- oACG_PHY_WriteEnable / ReadEnable / CommandLatchEnable / AddressLatchEnable  out  4 each  pin levels; bit 0 is earliest in the clock
- oACG_PHY_DQ  out  32  byte replicated in all four lanes
- oACG_PHY_DQOutEnable / DQSOutEnable  out  1/1  DQ drive enable / constant 0
- oACG_PHY_DQStrobe  out  8  constant 0
- iPHY_ACG_ReadyBusy  in  NumberOfWays  synchronized R/B, 1 = ready

## Operation
- States: IDLE, CE_SETUP, CMD1_LO, CMD1_HI, ADDR_LO, ADDR_HI, CMD2_LO, CMD2_HI, HOLD, [WAIT_TWB, WAIT_RB], DONE.
- IDLE:
  - oCmd_Ready=1.
  - On Valid&Ready, latch the descriptor.
  - Effective address count is min(AddrCount, MaxAddrBytes).
- CE_SETUP: lasts CESetupCycles. Target CE=2'b11, WE=4'hF, CLE=ALE=0, DQOutEnable=0.
- Byte slots:
  - Each byte takes 2 cycles: LO has WE=4'h0; HI has WE=4'hF.
  - DQ = {4{byte}} and DQOutEnable=1 in both cycles.
  - CLE=4'hF for CMD1/CMD2 slots. ALE=4'hF for ADDR slots. The other latch enable is 0.
- Slot order: CMD1, then ADDR bytes 0..n-1 (skipped when n=0), then CMD2 only if HasSecond. The next slot follows with no gap.
- HOLD: lasts HoldCycles. CE asserted, CLE=ALE=0, WE=4'hF, DQOutEnable=0, DQ=0.
- DONE: lasts 1 cycle. oDone=1, all CE=0, Ready=0. Next state is IDLE.
- RE is always 4'hF. Non-target ways always have CE=0.
- Reset is asynchronous at any point. It forces IDLE, and an aborted command produces no oDone.
- Idle/reset output values: Ready=1, Done=0, CE=0, WE=RE=4'hF, CLE=ALE=0, DQ=0, DQOutEnable=DQSOutEnable=0, DQStrobe=0.

## Timing
- Accept happens at clock edge T0; CE_SETUP starts in cycle T0+1.
- oDone is high in cycle T0 + CESetupCycles + 2·(1+n+HasSecond) + HoldCycles + 1.
  - Defaults, n=5, no second opcode: oDone at T0+17.
  - n=0, no second opcode: oDone at T0+7.
- oCmd_Ready returns the cycle after oDone.
- Minimum command-to-command spacing is therefore latency+1 cycles.
- iCmd_* is sampled only at accept. Changes after accept are ignored.
- Valid held high across DONE: the descriptor is accepted in the first IDLE cycle.

## Configuration
- NFC_CMD_RB_WAIT_EN defined:
  - HOLD is followed by WAIT_TWB (TwbCycles cycles), then WAIT_RB.
  - WAIT_RB holds CE asserted until iPHY_ACG_ReadyBusy[TargetID]==1, then goes to DONE.
  - R/B already high after tWB gives DONE the next cycle.
  - There is no timeout.
- Not defined: HOLD goes straight to DONE, the WAIT states are not built, and iPHY_ACG_ReadyBusy is unused.

## Test plan
- Reset release: check all idle values. Ready=1, WE=4'hF, CE=8'h00.
- Opcode 8'h00, 5 addr bytes {01,02,03,04,05}, opcode2 8'h30, target 2:
  - CE[5:4]=2'b11 only.
  - DQ sequence is 00000000, 01010101, … 05050505, 30303030.
  - CLE on the first and last slots only.
  - oDone at T0+19.
- Opcode 8'hFF, AddrCount=0, no second opcode, target 0: one CLE slot, no ALE, oDone at T0+7.
- AddrCount=7: clamped to 5 address slots; oDone timing is the same as n=5.
- Assert reset during ADDR_HI of byte 2: outputs go to idle values immediately, no oDone, and the next command completes normally.
- With NFC_CMD_RB_WAIT_EN, hold RB[1]=0 for 30 cycles after tWB: CE for way 1 stays 2'b11, and oDone comes exactly 1 cycle after RB[1] rises.
